cmd_frame_parser: RTL and testbench

Consumes the 8-bit byte stream from the read side of the 64-deep asynchronous command FIFO and assembles 5-byte command frames: sync, address, data high, data low, checksum. Valid frames are presented to the register/control bank over a valid/ready handshake. Checksum failures and inter-byte timeouts are flagged and the frame is dropped. Runs entirely in the FIFO read-clock domain.

---
 rtl/cmd_frame_pkg.sv | 29 ++
 rtl/cmd_timeout_cnt.sv | 36 +++
 rtl/cmd_frame_parser.sv | 194 +++++++++++++++++++
 tb/tb_cmd_frame_parser.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cmd_frame_pkg.sv
// Shared definitions for the command frame parser.
//   state_t           : parser state encoding
//   FRAME_LEN         : bytes per frame (sync, addr, data_hi, data_lo, checksum)
//   SYNC_BYTE_DEFAULT : default frame start marker
//   checksum8()       : 8-bit wrapping sum of the three payload bytes
package cmd_frame_pkg;

    typedef enum logic [2:0] {
        HUNT = 3'd0,
        ADDR = 3'd1,
        DHI  = 3'd2,
        DLO  = 3'd3,
        CHK  = 3'd4,
        OUT  = 3'd5
    } state_t;

    localparam int unsigned FRAME_LEN         = 32'd5;
    localparam logic [7:0]  SYNC_BYTE_DEFAULT = 8'hAA;

    // Carries out of bit 7 are dropped on purpose: the checksum wraps mod 256.
    function automatic logic [7:0] checksum8(input logic [7:0] a,
                                             input logic [7:0] b,
                                             input logic [7:0] c);
        logic [9:0] sum_s;
        sum_s = {2'b00, a} + {2'b00, b} + {2'b00, c};
        return sum_s[7:0];
    endfunction

endpackage

// File: rtl/cmd_timeout_cnt.sv
// Inter-byte idle counter for the frame parser.
//   clk, reset : clock and synchronous active-high reset
//   clear      : return the count to zero (wins over enable)
//   enable     : advance the count by one
//   terminal   : count has reached TIMEOUT_CYCLES-1
module cmd_timeout_cnt #(
    parameter int unsigned TIMEOUT_CYCLES = 32'd1024,
    parameter int unsigned TO_W           = $clog2(TIMEOUT_CYCLES)
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic terminal
);

    localparam logic [TO_W-1:0] TC_VAL = TO_W'(TIMEOUT_CYCLES - 32'd1);

    logic [TO_W-1:0] cnt_r;

    // Idle counter; the owner clears it at terminal count so it never wraps.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_r <= TO_W'(0);
        end else if (clear) begin
            cnt_r <= TO_W'(0);
        end else if (enable) begin
            cnt_r <= cnt_r + TO_W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign terminal = (cnt_r == TC_VAL);

endmodule

// File: rtl/cmd_frame_parser.sv
// Assembles 5-byte command frames (sync, addr, data_hi, data_lo, checksum)
// from a non-FWFT FIFO read port and presents them over valid/ready.
//   clk, reset   : FIFO read clock, synchronous active-high reset
//   fifo_empty   : FIFO empty flag
//   fifo_q       : FIFO read data, valid the cycle after fifo_re
//   fifo_re      : FIFO read enable
//   cmd_valid    : command available (held until cmd_ready)
//   cmd_ready    : consumer accepts the command
//   cmd_addr     : command address
//   cmd_data     : command data {data_hi, data_lo}
//   err_checksum : one-cycle pulse, frame dropped on bad checksum
//   err_timeout  : one-cycle pulse, frame aborted on inter-byte timeout
module cmd_frame_parser
    import cmd_frame_pkg::*;
#(
    parameter logic [7:0]  SYNC_BYTE      = SYNC_BYTE_DEFAULT,
    parameter int unsigned TIMEOUT_CYCLES = 32'd1024,
    parameter int unsigned TO_W           = $clog2(TIMEOUT_CYCLES)
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        fifo_empty,
    input  logic [7:0]  fifo_q,
    output logic        fifo_re,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    output logic [7:0]  cmd_addr,
    output logic [15:0] cmd_data,
    output logic        err_checksum,
    output logic        err_timeout
);

    state_t     state_r;
    state_t     state_nxt_s;
    logic       rd_pend_r;
    logic       fifo_re_s;
    logic       byte_evt_s;
    logic       active_s;
    logic       tc_s;
    logic       timeout_s;
    logic       to_clear_s;
    logic [7:0] addr_r;
    logic [7:0] dhi_r;
    logic [7:0] dlo_r;
    logic       cap_addr_s;
    logic       cap_dhi_s;
    logic       cap_dlo_s;
    logic       err_cks_nxt_s;
    logic       err_to_nxt_s;
    logic       cmd_valid_r;
    logic       err_checksum_r;
    logic       err_timeout_r;

    // A read is issued only when a byte can be absorbed: never in OUT, and in
    // CHK not while the checksum byte is still in flight, so no byte can land
    // while the command is being held. Reset gates it so all outputs read 0.
    assign fifo_re_s = !reset && !fifo_empty && (state_r != OUT) &&
                       !((state_r == CHK) && rd_pend_r);

    assign byte_evt_s = rd_pend_r;
    assign active_s   = (state_r == ADDR) || (state_r == DHI) ||
                        (state_r == DLO)  || (state_r == CHK);
    // A byte arriving on the terminal cycle takes priority over the timeout.
    assign timeout_s  = active_s && tc_s && !byte_evt_s;
    // Entry to ADDR always comes from a byte event in HUNT, so it is covered here.
    assign to_clear_s = byte_evt_s || !active_s || timeout_s;

    cmd_timeout_cnt #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .TO_W           (TO_W)
    ) u_timeout (
        .clk      (clk),
        .reset    (reset),
        .clear    (to_clear_s),
        .enable   (active_s),
        .terminal (tc_s)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= HUNT;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state, capture strobes and error pulse requests.
    always_comb begin
        state_nxt_s   = state_r;
        cap_addr_s    = 1'b0;
        cap_dhi_s     = 1'b0;
        cap_dlo_s     = 1'b0;
        err_cks_nxt_s = 1'b0;
        err_to_nxt_s  = 1'b0;
        case (state_r)
            HUNT: begin
                if (byte_evt_s && (fifo_q == SYNC_BYTE)) begin
                    state_nxt_s = ADDR;
                end else begin
                    state_nxt_s = HUNT;
                end
            end
            ADDR: begin
                if (byte_evt_s) begin
                    cap_addr_s  = 1'b1;
                    state_nxt_s = DHI;
                end else if (timeout_s) begin
                    err_to_nxt_s = 1'b1;
                    state_nxt_s  = HUNT;
                end else begin
                    state_nxt_s = ADDR;
                end
            end
            DHI: begin
                if (byte_evt_s) begin
                    cap_dhi_s   = 1'b1;
                    state_nxt_s = DLO;
                end else if (timeout_s) begin
                    err_to_nxt_s = 1'b1;
                    state_nxt_s  = HUNT;
                end else begin
                    state_nxt_s = DHI;
                end
            end
            DLO: begin
                if (byte_evt_s) begin
                    cap_dlo_s   = 1'b1;
                    state_nxt_s = CHK;
                end else if (timeout_s) begin
                    err_to_nxt_s = 1'b1;
                    state_nxt_s  = HUNT;
                end else begin
                    state_nxt_s = DLO;
                end
            end
            CHK: begin
                if (byte_evt_s) begin
                    if (fifo_q == checksum8(addr_r, dhi_r, dlo_r)) begin
                        state_nxt_s = OUT;
                    end else begin
                        err_cks_nxt_s = 1'b1;
                        state_nxt_s   = HUNT;
                    end
                end else if (timeout_s) begin
                    err_to_nxt_s = 1'b1;
                    state_nxt_s  = HUNT;
                end else begin
                    state_nxt_s = CHK;
                end
            end
            OUT: begin
                if (cmd_ready) begin
                    state_nxt_s = HUNT;
                end else begin
                    state_nxt_s = OUT;
                end
            end
            default: begin
                state_nxt_s = HUNT;
            end
        endcase
    end

    // Read-pending flag, payload capture and registered outputs. The payload
    // registers only change in ADDR/DHI/DLO, so they are stable throughout OUT.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_pend_r      <= 1'b0;
            addr_r         <= 8'h00;
            dhi_r          <= 8'h00;
            dlo_r          <= 8'h00;
            cmd_valid_r    <= 1'b0;
            err_checksum_r <= 1'b0;
            err_timeout_r  <= 1'b0;
        end else begin
            rd_pend_r      <= fifo_re_s;
            addr_r         <= cap_addr_s ? fifo_q : addr_r;
            dhi_r          <= cap_dhi_s  ? fifo_q : dhi_r;
            dlo_r          <= cap_dlo_s  ? fifo_q : dlo_r;
            cmd_valid_r    <= (state_nxt_s == OUT);
            err_checksum_r <= err_cks_nxt_s;
            err_timeout_r  <= err_to_nxt_s;
        end
    end

    assign fifo_re      = fifo_re_s;
    assign cmd_valid    = cmd_valid_r;
    assign cmd_addr     = addr_r;
    assign cmd_data     = {dhi_r, dlo_r};
    assign err_checksum = err_checksum_r;
    assign err_timeout  = err_timeout_r;

endmodule

// File: tb/tb_cmd_frame_parser.sv
// Directed bench for cmd_frame_parser: a behavioural non-FWFT FIFO feeds
// hand-built frames, a negedge monitor logs handshakes and error pulses.
module tb_cmd_frame_parser;
    import cmd_frame_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        fifo_empty;
    logic [7:0]  fifo_q = 8'h00;
    logic        fifo_re;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [7:0]  cmd_addr;
    logic [15:0] cmd_data;
    logic        err_checksum;
    logic        err_timeout;

    logic [7:0] mem [0:255];
    int wr_cnt = 0;
    int rd_cnt = 0;
    int cyc = 0;

    int n_checks = 0;
    int n_fail = 0;
    int n_cks = 0;
    int n_to = 0;
    logic [7:0]  got_addr [$];
    logic [15:0] got_data [$];
    int          xfer_cyc [$];
    int          to_cyc [$];

    cmd_frame_parser #(
        .SYNC_BYTE      (8'hAA),
        .TIMEOUT_CYCLES (32'd16)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .fifo_empty   (fifo_empty),
        .fifo_q       (fifo_q),
        .fifo_re      (fifo_re),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_addr     (cmd_addr),
        .cmd_data     (cmd_data),
        .err_checksum (err_checksum),
        .err_timeout  (err_timeout)
    );

    always #5 clk = ~clk;

    assign fifo_empty = (wr_cnt == rd_cnt);

    // Behavioural FIFO read port: data appears the cycle after fifo_re.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (fifo_re && (wr_cnt != rd_cnt)) begin
            fifo_q <= mem[rd_cnt];
            rd_cnt <= rd_cnt + 1;
        end
    end

    // Monitor: record transfers and error pulses mid-cycle.
    always @(negedge clk) begin
        if (!reset) begin
            if (cmd_valid && cmd_ready) begin
                got_addr.push_back(cmd_addr);
                got_data.push_back(cmd_data);
                xfer_cyc.push_back(cyc);
            end
            if (err_checksum) n_cks = n_cks + 1;
            if (err_timeout) begin
                n_to = n_to + 1;
                to_cyc.push_back(cyc);
            end
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] b);
        mem[wr_cnt] = b;
        wr_cnt = wr_cnt + 1;
    endtask

    task automatic push_frame(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                              input logic [7:0] b3, input logic [7:0] b4);
        push(b0); push(b1); push(b2); push(b3); push(b4);
    endtask

    task automatic wait_cmds(input int target, input int budget);
        int k;
        k = 0;
        while ((got_addr.size() < target) && (k < budget)) begin
            tick(1);
            k = k + 1;
        end
    endtask

    function automatic logic [31:0] ga(input int i);
        if (i < got_addr.size()) return {24'h0, got_addr[i]};
        else return 32'hDEAD_BEEF;
    endfunction

    function automatic logic [31:0] gd(input int i);
        if (i < got_data.size()) return {16'h0, got_data[i]};
        else return 32'hDEAD_BEEF;
    endfunction

    function automatic logic [31:0] gx(input int i);
        if (i < xfer_cyc.size()) return xfer_cyc[i];
        else return 32'hDEAD_BEEF;
    endfunction

    task automatic check_outputs_zero(input string pfx);
        check_eq({pfx, "_re"},    {31'h0, fifo_re},      32'h0);
        check_eq({pfx, "_valid"}, {31'h0, cmd_valid},    32'h0);
        check_eq({pfx, "_addr"},  {24'h0, cmd_addr},     32'h0);
        check_eq({pfx, "_data"},  {16'h0, cmd_data},     32'h0);
        check_eq({pfx, "_ecks"},  {31'h0, err_checksum}, 32'h0);
        check_eq({pfx, "_eto"},   {31'h0, err_timeout},  32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int p;
        int c0;
        int t0;
        int vcount;
        int bad;

        reset = 1'b1;
        cmd_ready = 1'b0;
        tick(3);
        @(negedge clk);
        check_outputs_zero("reset");
        tick(1);
        reset = 1'b0;
        tick(2);

        // Clean frame followed back-to-back by a second one: latency and period.
        cmd_ready = 1'b1;
        base = got_addr.size();
        p = cyc;
        push_frame(8'hAA, 8'h12, 8'h34, 8'h56, 8'h9C);
        push_frame(8'hAA, 8'h21, 8'h43, 8'h65, 8'hC9);
        wait_cmds(base + 2, 60);
        tick(3);
        check_eq("clean_count", got_addr.size(), base + 2);
        check_eq("clean_addr0", ga(base), 32'h12);
        check_eq("clean_data0", gd(base), 32'h3456);
        check_eq("clean_addr1", ga(base + 1), 32'h21);
        check_eq("clean_data1", gd(base + 1), 32'h4365);
        check_eq("clean_latency", gx(base) - p, 32'd6);
        check_eq("clean_period", gx(base + 1) - gx(base), 32'd7);
        check_eq("clean_no_cks", n_cks, 32'd0);
        check_eq("clean_no_to", n_to, 32'd0);

        // Bad checksum, then recovery on the next frame.
        c0 = n_cks;
        base = got_addr.size();
        push_frame(8'hAA, 8'h12, 8'h34, 8'h56, 8'h9D);
        push_frame(8'hAA, 8'h01, 8'h00, 8'h01, 8'h02);
        wait_cmds(base + 1, 60);
        tick(5);
        check_eq("badcks_pulses", n_cks - c0, 32'd1);
        check_eq("badcks_count", got_addr.size(), base + 1);
        check_eq("badcks_addr", ga(base), 32'h01);
        check_eq("badcks_data", gd(base), 32'h0001);

        // Garbage before sync; sync byte as address; checksum wraps.
        c0 = n_cks;
        base = got_addr.size();
        push(8'h00); push(8'h55);
        push_frame(8'hAA, 8'hAA, 8'hFF, 8'hFF, 8'hA8);
        wait_cmds(base + 1, 60);
        tick(5);
        check_eq("garb_count", got_addr.size(), base + 1);
        check_eq("garb_addr", ga(base), 32'hAA);
        check_eq("garb_data", gd(base), 32'hFFFF);
        check_eq("garb_no_cks", n_cks - c0, 32'd0);

        // Timeout after sync+addr, then a normal frame.
        t0 = n_to;
        base = got_addr.size();
        p = cyc;
        push(8'hAA); push(8'h12);
        tick(40);
        check_eq("to_pulses", n_to - t0, 32'd1);
        check_eq("to_cycle", (to_cyc.size() > t0) ? (to_cyc[t0] - p) : -1, 32'd19);
        check_eq("to_no_cmd", got_addr.size(), base);
        push_frame(8'hAA, 8'h12, 8'h34, 8'h56, 8'h9C);
        wait_cmds(base + 1, 60);
        tick(3);
        check_eq("to_recover_addr", ga(base), 32'h12);
        check_eq("to_recover_data", gd(base), 32'h3456);
        check_eq("to_recover_no_to", n_to - t0, 32'd1);

        // Backpressure: hold the consumer off for 50 cycles.
        cmd_ready = 1'b0;
        base = got_addr.size();
        push_frame(8'hAA, 8'h12, 8'h34, 8'h56, 8'h9C);
        push_frame(8'hAA, 8'h21, 8'h43, 8'h65, 8'hC9);
        vcount = 0;
        bad = 0;
        repeat (50) begin
            @(negedge clk);
            if (cmd_valid) begin
                vcount = vcount + 1;
                if (fifo_re || (cmd_addr !== 8'h12) || (cmd_data !== 16'h3456)) bad = bad + 1;
            end
        end
        check_eq("bp_valid_cycles", vcount, 32'd44);
        check_eq("bp_stable", bad, 32'd0);
        check_eq("bp_no_xfer", got_addr.size(), base);
        tick(1);
        cmd_ready = 1'b1;
        wait_cmds(base + 2, 60);
        tick(3);
        check_eq("bp_count", got_addr.size(), base + 2);
        check_eq("bp_addr0", ga(base), 32'h12);
        check_eq("bp_data0", gd(base), 32'h3456);
        check_eq("bp_addr1", ga(base + 1), 32'h21);
        check_eq("bp_data1", gd(base + 1), 32'h4365);

        // Reset one cycle after the data_hi byte event.
        c0 = n_cks;
        p = cyc;
        push_frame(8'hAA, 8'h12, 8'h34, 8'h56, 8'h9C);
        tick(4);
        reset = 1'b1;
        tick(1);
        @(negedge clk);
        check_outputs_zero("midrst");
        check_eq("midrst_state", {29'h0, dut.state_r}, {29'h0, HUNT});
        tick(1);
        reset = 1'b0;
        base = got_addr.size();
        push_frame(8'hAA, 8'h5A, 8'h00, 8'h01, 8'h5B);
        wait_cmds(base + 1, 60);
        tick(5);
        check_eq("midrst_count", got_addr.size(), base + 1);
        check_eq("midrst_addr", ga(base), 32'h5A);
        check_eq("midrst_data", gd(base), 32'h0001);
        check_eq("midrst_no_cks", n_cks - c0, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
